weight_stream_loader: RTL and testbench
=======================================

# weight_stream_loader

Packs a byte-wide weight stream from the DMA/stream interface into full-width weight-memory words and issues the write strobes, addresses and data for the weight BRAM port A. It sits directly upstream of the weight memory write path of the WeightMemoryUnit. One `start` pulse loads one tile of `TILE_WORDS` words, and the tile's end is reported to the DRM control FSM with `load_done`.

## Interface
- `DATA_WIDTH`, 8: width of one stream element (one weight).
- `PACK_NUM`, 4: elements per memory word; must be ≥2.
- `WR_ADDR_DEPTH`, 10: memory write address width.
- `TILE_WORDS`, 576: words per tile; must satisfy 1 ≤ `TILE_WORDS` ≤ 2^`WR_ADDR_DEPTH`.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rstn`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle pulse that begins a tile load; ignored unless in IDLE.
- `abort`, in, 1: synchronous cancel; returns the block to IDLE.
- `s_data`, in, `DATA_WIDTH`: stream element.
- `s_valid`, in, 1: `s_data` is valid.
- `s_ready`, out, 1: block accepts an element this cycle.
- `wr_en`, out, 1: memory write strobe.
- `wr_addr`, out, `WR_ADDR_DEPTH`: memory write address.
- `wr_data`, out, `DATA_WIDTH*PACK_NUM`: packed word.
- `busy`, out, 1: high in any state other than IDLE.
- `load_done`, out, 1: one-cycle pulse at the end of a tile.

## Operation
The FSM has three states: IDLE, LOAD and DONE.

- **IDLE → LOAD** on `start`. Entering LOAD clears the lane counter and the word counter to 0 and sets the address to 0.
- **LOAD:**
  - `s_ready`=1. An element is accepted when `s_valid & s_ready`.
  - An accepted element is written into lane `lane_cnt`. Lane 0 occupies `wr_data[DATA_WIDTH-1:0]`, so the first element lands in the lowest lane.
  - `lane_cnt` increments on each accept and wraps from `PACK_NUM-1` to 0.
  - Accepting the element in lane `PACK_NUM-1` completes a word. On the next cycle `wr_en`=1 with the packed word on `wr_data` and the current `wr_addr`. After that write the address increments and `word_cnt` increments.
  - When the completing element is the last word of the tile (`word_cnt`=`TILE_WORDS-1`), the FSM goes to DONE. `s_ready` drops in the cycle after that accept.
- **DONE:** `load_done`=1 for exactly one cycle, then the FSM returns to IDLE.
- **abort:** in any state, `abort` forces IDLE on the next edge. It clears the counters, `wr_en`, `s_ready` and `busy`. No `load_done` is produced. A partially packed word is discarded. `abort` takes priority over `start` and over a simultaneous accept.
- **start while busy:** ignored; no restart.
- **Stream stalls:** `s_valid`=0 gaps are tolerated with no limit. Lane and word state are held.
- **Address range:** `wr_addr` never exceeds `TILE_WORDS-1`. No wrap occurs inside a tile.

## Timing
- **Reset values:** state IDLE, `s_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `load_done`=0.
- `wr_en`, `wr_addr`, `wr_data` and `load_done` are registered outputs. `s_ready` is decoded from the state register only.
- **Write latency:** a word-completing accept at cycle N gives `wr_en`=1 at N+1. The address advances at N+2.
- **Throughput:** one element per cycle, so one write every `PACK_NUM` cycles at full rate.
- `start` at cycle N gives `s_ready`=1 at N+1.
- **Tile end:** the final accept at cycle N gives the final `wr_en` at N+1 and `load_done` at N+2. `busy`=0 and a new `start` is accepted at N+3.
- `wr_data` holds its value when `wr_en`=0. Downstream logic must qualify `wr_data` with `wr_en`.

## Structure
- The shared DRM package holds:
  - the state encodings `ST_IDLE`, `ST_LOAD`, `ST_DONE` as 2-bit localparams;
  - the defaults for `DATA_WIDTH` and `PACK_NUM`;
  - the default for `WR_ADDR_DEPTH`, shared with the weight controller.
- One sub-module, `weight_lane_packer`. It contains the lane counter and the `PACK_NUM`-lane register, and its outputs are the packed word plus a `word_valid` pulse. The FSM and address/word counters stay in the top module.

## Test plan
- **Basic tile:** `TILE_WORDS`=4, `PACK_NUM`=4, `s_valid` held high with elements 0x00…0x0F, then `start`. Expect 4 writes at addresses 0–3: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. Expect `load_done` exactly 1 cycle after the last `wr_en`, and `s_ready` low afterward.
- **Backpressure gaps:** `s_valid` toggling 1/0 every cycle. Expect identical data and addresses to the basic tile, with writes spaced 8 cycles apart and no duplicated or dropped lane.
- **Abort mid-word:** `abort` asserted after 6 elements. Expect exactly 1 write (address 0), no `load_done`, and `busy`=0 on the next cycle. A following `start` writes from address 0 again with lane 0 fresh.
- **start during LOAD:** a second `start` pulse at element 5. Expect no effect, and the tile completes with 4 writes.
- **Async reset mid-tile:** `rstn` low between clock edges during word 2. Expect all outputs at their reset values immediately, and `s_ready`=0 until the next `start`.
- **Full-size tile:** `TILE_WORDS`=576 with default `WR_ADDR_DEPTH`. Expect 576 writes with the last at address 575, `load_done` exactly once, and `wr_addr` never reaching 576.

Source files
------------

// File: rtl/weight_stream_loader_pkg.sv
// Shared DRM definitions: loader FSM state encodings and default widths,
// including the write-address width also used by the weight controller.
package weight_stream_loader_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_PACK_NUM      = 4;
    localparam int DEF_WR_ADDR_DEPTH = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/weight_lane_packer.sv
// Collects PACK_NUM stream elements into one memory word, lane 0 in the LSBs,
// and emits a one-cycle word_valid alongside the registered word.
module weight_lane_packer
    import weight_stream_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK_NUM   = DEF_PACK_NUM
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clr,
    input  logic                           accept,
    input  logic [DATA_WIDTH-1:0]          data,
    output logic                           lane_last,
    output logic [DATA_WIDTH*PACK_NUM-1:0] word,
    output logic                           word_valid
);

    localparam int LW = $clog2(PACK_NUM);
    localparam int WW = DATA_WIDTH * PACK_NUM;
    localparam logic [LW-1:0] LAST_LANE = LW'(PACK_NUM - 1);

    logic [LW-1:0] lane_cnt_q, lane_cnt_d;
    logic [WW-1:0] lanes_q, lanes_d;
    logic [WW-1:0] word_q, word_d;
    logic          word_valid_q, word_valid_d;

    assign lane_last  = (lane_cnt_q == LAST_LANE);
    assign word       = word_q;
    assign word_valid = word_valid_q;

    // Stale lanes are never cleared: every lane is rewritten before a word
    // completes, so resetting the lane counter is enough to discard a partial word.
    always_comb begin
        lane_cnt_d   = lane_cnt_q;
        lanes_d      = lanes_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clr) begin
            lane_cnt_d = '0;
        end else if (accept) begin
            lanes_d[lane_cnt_q*DATA_WIDTH +: DATA_WIDTH] = data;
            if (lane_last) begin
                lane_cnt_d   = '0;
                word_d       = lanes_d;
                word_valid_d = 1'b1;
            end else begin
                lane_cnt_d = lane_cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_cnt_q   <= '0;
            lanes_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            lanes_q      <= lanes_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: rtl/weight_stream_loader.sv
// Loads one tile of TILE_WORDS packed weight words from a byte stream into the
// weight BRAM write port, then pulses load_done to the DRM control FSM.
module weight_stream_loader
    import weight_stream_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int PACK_NUM      = DEF_PACK_NUM,
    parameter int WR_ADDR_DEPTH = DEF_WR_ADDR_DEPTH,
    parameter int TILE_WORDS    = 576
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic                           abort,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic                           wr_en,
    output logic [WR_ADDR_DEPTH-1:0]       wr_addr,
    output logic [DATA_WIDTH*PACK_NUM-1:0] wr_data,
    output logic                           busy,
    output logic                           load_done,
    output state_t                         dbg_state
);

    localparam logic [WR_ADDR_DEPTH-1:0] LAST_WORD = WR_ADDR_DEPTH'(TILE_WORDS - 1);

    state_t                   state_q, state_d;
    logic [WR_ADDR_DEPTH-1:0] addr_q, addr_d;
    logic [WR_ADDR_DEPTH-1:0] word_cnt_q, word_cnt_d;
    logic                     load_done_q, load_done_d;
    logic                     accept, start_load, pack_clr;
    logic                     lane_last, word_valid;

    // Stream handshake: an element transfers on a rising edge where
    // s_valid & s_ready are both high; s_ready depends on state only, and an
    // abort in the same cycle cancels the transfer.
    assign s_ready    = (state_q == ST_LOAD);
    assign accept     = s_valid & s_ready & ~abort;
    assign start_load = (state_q == ST_IDLE) & start & ~abort;
    assign pack_clr   = abort | start_load;

    weight_lane_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK_NUM   (PACK_NUM)
    ) u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (pack_clr),
        .accept     (accept),
        .data       (s_data),
        .lane_last  (lane_last),
        .word       (wr_data),
        .word_valid (word_valid)
    );

    // DONE spans two cycles: the final write, then the load_done pulse, so
    // busy stays high until load_done has been seen.
    always_comb begin
        state_d     = state_q;
        load_done_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_LOAD;
                ST_LOAD: if (accept && lane_last && (word_cnt_q == LAST_WORD)) state_d = ST_DONE;
                ST_DONE: begin
                    load_done_d = word_valid;
                    if (load_done_q) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The address is held on the final word so it never leaves the tile.
    always_comb begin
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        if (abort || start_load) begin
            addr_d     = '0;
            word_cnt_d = '0;
        end else if (word_valid && (word_cnt_q != LAST_WORD)) begin
            addr_d     = addr_q + WR_ADDR_DEPTH'(1);
            word_cnt_d = word_cnt_q + WR_ADDR_DEPTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            word_cnt_q  <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            word_cnt_q  <= word_cnt_d;
            load_done_q <= load_done_d;
        end
    end

    assign wr_en     = word_valid;
    assign wr_addr   = addr_q;
    assign load_done = load_done_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed + randomized bench for weight_stream_loader: a 4-word-tile instance
// and a full 576-word-tile instance, checked against a word-packing model.
module tb_weight_stream_loader;
    import weight_stream_loader_pkg::*;

    localparam int DW    = 8;
    localparam int PN    = 4;
    localparam int AW    = 10;
    localparam int WW    = DW * PN;
    localparam int SMALL = 4;
    localparam int BIG   = 576;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          start_s, start_b, abort, s_valid;
    logic [DW-1:0] s_data;

    logic          s_ready_s, wr_en_s, busy_s, load_done_s;
    logic [AW-1:0] wr_addr_s;
    logic [WW-1:0] wr_data_s;
    state_t        dbg_state_s;

    logic          s_ready_b, wr_en_b, busy_b, load_done_b;
    logic [AW-1:0] wr_addr_b;
    logic [WW-1:0] wr_data_b;
    state_t        dbg_state_b;

    weight_stream_loader #(
        .DATA_WIDTH(DW), .PACK_NUM(PN), .WR_ADDR_DEPTH(AW), .TILE_WORDS(SMALL)
    ) u_small (
        .clk(clk), .rstn(rstn), .start(start_s), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_s),
        .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
        .busy(busy_s), .load_done(load_done_s), .dbg_state(dbg_state_s)
    );

    weight_stream_loader #(
        .DATA_WIDTH(DW), .PACK_NUM(PN), .WR_ADDR_DEPTH(AW), .TILE_WORDS(BIG)
    ) u_big (
        .clk(clk), .rstn(rstn), .start(start_b), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .load_done(load_done_b), .dbg_state(dbg_state_b)
    );

    // Monitor follows whichever instance the current step targets.
    logic          sel;
    logic          m_s_ready, m_wr_en, m_busy, m_load_done;
    logic [AW-1:0] m_wr_addr;
    logic [WW-1:0] m_wr_data;
    state_t        m_state;

    assign m_s_ready   = sel ? s_ready_b   : s_ready_s;
    assign m_wr_en     = sel ? wr_en_b     : wr_en_s;
    assign m_busy      = sel ? busy_b      : busy_s;
    assign m_load_done = sel ? load_done_b : load_done_s;
    assign m_wr_addr   = sel ? wr_addr_b   : wr_addr_s;
    assign m_wr_data   = sel ? wr_data_b   : wr_data_s;
    assign m_state     = sel ? dbg_state_b : dbg_state_s;

    // ---------------- scoreboard ----------------
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] obs_data[$];
    logic [AW-1:0] obs_addr[$];
    int            obs_cyc[$];
    int            done_cyc[$];
    int            idle_cyc;
    int            max_addr;
    logic          busy_prev;
    logic [DW-1:0] elems[$];
    int            last_acc;
    int            n_cmp = 0;
    int            n_err = 0;

    always @(negedge clk) begin
        if (m_wr_en) begin
            obs_addr.push_back(m_wr_addr);
            obs_data.push_back(m_wr_data);
            obs_cyc.push_back(cyc);
        end
        if (m_load_done) done_cyc.push_back(cyc);
        if (busy_prev && !m_busy) idle_cyc = cyc;
        busy_prev = m_busy;
        if (int'(m_wr_addr) > max_addr) max_addr = int'(m_wr_addr);
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        done_cyc.delete();
        idle_cyc = -1;
        max_addr = 0;
    endtask

    task automatic fill_elems(input int n, input bit ramp);
        elems.delete();
        for (int i = 0; i < n; i++) elems.push_back(ramp ? DW'(i) : DW'($urandom_range(0, 255)));
    endtask

    // Reference: consecutive groups of PN elements, first element in the low lane.
    task automatic build_expected(input int n_words);
        exp_q.delete();
        for (int w = 0; w < n_words; w++) begin
            logic [WW-1:0] word;
            word = '0;
            for (int l = 0; l < PN; l++) word[l*DW +: DW] = elems[w*PN + l];
            exp_q.push_back(word);
        end
    endtask

    task automatic do_start(input string tag);
        if (sel) start_b = 1'b1; else start_s = 1'b1;
        tick();
        start_b = 1'b0;
        start_s = 1'b0;
        chk({tag, " ready_after_start"}, 64'(m_s_ready), 64'd1);
    endtask

    // gap: 0 = back-to-back, 1 = alternate idle cycles, 2 = random idle runs
    task automatic send_elems(input string tag, input int first, input int count,
                              input int gap, input int restart_at);
        int not_ready = 0;
        for (int i = first; i < first + count; i++) begin
            s_valid = 1'b1;
            s_data  = elems[i];
            if (i == restart_at) begin
                if (sel) start_b = 1'b1; else start_s = 1'b1;
            end
            if (!m_s_ready) not_ready++;
            last_acc = cyc;
            tick();
            start_s = 1'b0;
            start_b = 1'b0;
            if (gap != 0) begin
                s_valid = 1'b0;
                s_data  = DW'($urandom_range(0, 255));
                if (gap == 1) tick();
                else repeat ($urandom_range(0, 2)) tick();
            end
        end
        s_valid = 1'b0;
        chk({tag, " ready_while_loading"}, 64'(not_ready), 64'd0);
    endtask

    task automatic check_tile(input string tag, input int spacing);
        chk({tag, " write_count"}, 64'(obs_data.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), 64'(obs_addr[i]), 64'(i));
            chk($sformatf("%s data[%0d]", tag, i), 64'(obs_data[i]), 64'(exp_q[i]));
            if (spacing > 0 && i > 0)
                chk($sformatf("%s spacing[%0d]", tag, i), 64'(obs_cyc[i] - obs_cyc[i-1]), 64'(spacing));
        end
        chk({tag, " load_done_count"}, 64'(done_cyc.size()), 64'd1);
        if (obs_cyc.size() > 0)
            chk({tag, " last_write_cycle"}, 64'(obs_cyc[obs_cyc.size()-1]), 64'(last_acc + 1));
        if (done_cyc.size() > 0)
            chk({tag, " load_done_cycle"}, 64'(done_cyc[0]), 64'(last_acc + 2));
        chk({tag, " busy_low_cycle"}, 64'(idle_cyc), 64'(last_acc + 3));
        chk({tag, " ready_after_tile"}, 64'(m_s_ready), 64'd0);
        chk({tag, " max_addr"}, 64'(max_addr), 64'(exp_q.size() - 1));
    endtask

    task automatic run_tile(input string tag, input bit ramp, input int words,
                            input int gap, input int restart_at, input int spacing);
        clear_obs();
        fill_elems(words * PN, ramp);
        build_expected(words);
        do_start(tag);
        send_elems(tag, 0, words * PN, gap, restart_at);
        repeat (6) tick();
        check_tile(tag, spacing);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int hold_ready;
        sel = 1'b0; rstn = 1'b0; start_s = 1'b0; start_b = 1'b0;
        abort = 1'b0; s_valid = 1'b0; s_data = '0;
        busy_prev = 1'b0; idle_cyc = -1; max_addr = 0; last_acc = 0;
        repeat (3) tick();

        chk("reset s_ready",   64'(m_s_ready),   64'd0);
        chk("reset wr_en",     64'(m_wr_en),     64'd0);
        chk("reset wr_addr",   64'(m_wr_addr),   64'd0);
        chk("reset wr_data",   64'(m_wr_data),   64'd0);
        chk("reset busy",      64'(m_busy),      64'd0);
        chk("reset load_done", 64'(m_load_done), 64'd0);
        chk("reset state",     64'(m_state),     64'(ST_IDLE));
        rstn = 1'b1;
        repeat (2) tick();

        // Basic tile: ramp 0x00..0x0F, back-to-back.
        run_tile("basic", 1'b1, SMALL, 0, -1, PN);
        if (obs_data.size() == SMALL) begin
            chk("basic literal word0", 64'(obs_data[0]), 64'h03020100);
            chk("basic literal word3", 64'(obs_data[3]), 64'h0F0E0D0C);
        end

        // Backpressure: s_valid toggles every cycle.
        run_tile("gaps", 1'b1, SMALL, 1, -1, 2 * PN);

        // Abort after 6 elements; a 7th element offered with abort must be dropped.
        clear_obs();
        fill_elems(6, 1'b0);
        build_expected(1);
        do_start("abort");
        send_elems("abort", 0, 6, 0, -1);
        s_valid = 1'b1;
        s_data  = DW'($urandom_range(0, 255));
        abort   = 1'b1;
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        chk("abort busy_next_cycle",  64'(m_busy),    64'd0);
        chk("abort ready_next_cycle", 64'(m_s_ready), 64'd0);
        repeat (4) tick();
        chk("abort write_count", 64'(obs_data.size()), 64'd1);
        if (obs_data.size() > 0) begin
            chk("abort addr[0]", 64'(obs_addr[0]), 64'd0);
            chk("abort data[0]", 64'(obs_data[0]), 64'(exp_q[0]));
        end
        chk("abort load_done_count", 64'(done_cyc.size()), 64'd0);
        run_tile("after_abort", 1'b0, SMALL, 0, -1, PN);

        // Second start at element 5 must be ignored.
        run_tile("restart_ignored", 1'b0, SMALL, 0, 4, PN);

        // Async reset between edges during word 2.
        clear_obs();
        fill_elems(9, 1'b1);
        do_start("reset_mid");
        send_elems("reset_mid", 0, 9, 0, -1);
        chk("reset_mid addr_before", 64'(m_wr_addr), 64'd2);
        #2 rstn = 1'b0;
        #1;
        chk("reset_mid s_ready",   64'(m_s_ready),   64'd0);
        chk("reset_mid wr_en",     64'(m_wr_en),     64'd0);
        chk("reset_mid wr_addr",   64'(m_wr_addr),   64'd0);
        chk("reset_mid wr_data",   64'(m_wr_data),   64'd0);
        chk("reset_mid busy",      64'(m_busy),      64'd0);
        chk("reset_mid load_done", 64'(m_load_done), 64'd0);
        #3 rstn = 1'b1;
        clear_obs();
        hold_ready = 0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = DW'($urandom_range(0, 255));
            tick();
            if (m_s_ready) hold_ready++;
        end
        s_valid = 1'b0;
        chk("reset_mid ready_until_start", 64'(hold_ready), 64'd0);
        chk("reset_mid no_writes", 64'(obs_data.size()), 64'd0);

        // Randomized tiles with random stalls.
        for (int t = 0; t < 3; t++)
            run_tile($sformatf("random%0d", t), 1'b0, SMALL, 2, -1, 0);

        // Full-size tile on the default-geometry instance.
        sel = 1'b1;
        repeat (2) tick();
        run_tile("full", 1'b0, BIG, 0, -1, PN);
        if (obs_addr.size() > 0)
            chk("full last_addr", 64'(obs_addr[obs_addr.size()-1]), 64'(BIG - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
